// File: rtl/mips_cpu_pkg.sv
// +----------------------------------------------------------------------+
// | mips_cpu_pkg : shared types and constants for the MIPS CPU front end |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/mips_cpu_fetch_if.sv
// +----------------------------------------------------------------------+
// | mips_cpu_fetch_if : Avalon-MM read-only instruction bus              |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mips_cpu_fetch_if #(
    parameter int ADDR_W = 32
);
    import mips_cpu_pkg::*;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    instr_t            avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

`default_nettype wire

// File: rtl/mips_cpu_sat_counter.sv
// +----------------------------------------------------------------------+
// | mips_cpu_sat_counter : up-counter that sticks at all-ones            |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module mips_cpu_sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_cpu_fetch.sv
// +----------------------------------------------------------------------+
// | mips_cpu_fetch : instruction fetch stage, one Avalon-MM read per PC  |
// | Option         : MIPS_CPU_FETCH_STALL_COUNT_EN enables stall_count   |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module mips_cpu_fetch #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR   = '0,
    parameter int                STALL_CNT_W = 16
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    input  wire logic [ADDR_W-1:0]       pc,
    input  wire logic                    exec_done,
    mips_cpu_fetch_if.master             avm,
    output mips_cpu_pkg::instr_t         instr,
    output logic                         instr_valid,
    output logic                         update_pc,
    output logic                         active,
    output logic                         fetch_fault,
    output logic [STALL_CNT_W-1:0]       stall_count
);

    import mips_cpu_pkg::*;

    fetch_state_t state;
    fetch_state_t state_nx;
    logic         update_pc_nx;
    logic         fault_nx;
    logic         capture;

    always_comb begin
        state_nx     = state;
        update_pc_nx = 1'b0;
        fault_nx     = fetch_fault;
        capture      = 1'b0;
        unique case (state)
            ISSUE: begin
                // While update_pc is high the PC block has not yet registered
                // the new PC, so sampling must wait one more cycle.
                if (!update_pc) begin
                    if (pc == HALT_ADDR) begin
                        state_nx = HALTED;
                    end else if (pc[1:0] != 2'b00) begin
                        state_nx = HALTED;
                        fault_nx = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!avm.avm_waitrequest) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (exec_done) begin
                    update_pc_nx = 1'b1;
                    state_nx     = ISSUE;
                end
            end
            default: begin
                state_nx = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ISSUE;
            update_pc   <= 1'b0;
            fetch_fault <= 1'b0;
            instr       <= '0;
        end else begin
            state       <= state_nx;
            update_pc   <= update_pc_nx;
            fetch_fault <= fault_nx;
            if (capture) begin
                instr <= avm.avm_readdata;
            end
        end
    end

    // All handshake outputs decode straight from the state register.
    assign avm.avm_address = pc;
    assign avm.avm_read    = (state == WAIT);
    assign instr_valid     = (state == HOLD);
    assign active          = (state != HALTED);

`ifdef MIPS_CPU_FETCH_STALL_COUNT_EN
    mips_cpu_sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     ((state == WAIT) && avm.avm_waitrequest),
        .count   (stall_count)
    );
`else
    assign stall_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_fetch.sv
// +----------------------------------------------------------------------+
// | tb_mips_cpu_fetch : self-checking bench for mips_cpu_fetch           |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mips_cpu_fetch;

`ifdef MIPS_CPU_FETCH_STALL_COUNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        exec_done = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        update_pc;
    logic        active;
    logic        fetch_fault;
    logic [15:0] stall_count;

    mips_cpu_fetch_if #(.ADDR_W(32)) bus ();

    mips_cpu_fetch #(
        .ADDR_W      (32),
        .HALT_ADDR   (32'h0),
        .STALL_CNT_W (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .exec_done   (exec_done),
        .avm         (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .update_pc   (update_pc),
        .active      (active),
        .fetch_fault (fetch_fault),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          waits;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          stall_total = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string name);
        check(name, 64'(stall_count), STALL_EN ? 64'(stall_total) : 64'd0);
    endtask

    // Entered with the DUT in ISSUE and update_pc already low.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word, input int waits);
        logic [31:0] exp;
        pc = addr;
        bus.avm_waitrequest = (waits > 0);
        bus.avm_readdata = ~word;
        tick();
        check("read_issued", 64'(bus.avm_read), 64'd1);
        check("read_addr", 64'(bus.avm_address), 64'(addr));
        for (int k = 0; k < waits; k++) begin
            tick();
            stall_total++;
            check("read_held", 64'(bus.avm_read), 64'd1);
            check("addr_held", 64'(bus.avm_address), 64'(addr));
            check("no_early_valid", 64'(instr_valid), 64'd0);
        end
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = word;
        exp_q.push_back(word);
        tick();
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata = 32'hA5A5_5A5A;
        check("instr_valid", 64'(instr_valid), 64'd1);
        check("read_dropped", 64'(bus.avm_read), 64'd0);
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got instr %0h expected none", instr);
        end else begin
            exp = exp_q.pop_front();
            check("instr", 64'(instr), 64'(exp));
        end
        check_stall("stall_count");
    endtask

    // Entered in HOLD; leaves the DUT in ISSUE with pc = next_pc visible.
    task automatic retire(input logic [31:0] expected_instr, input logic [31:0] next_pc);
        tick();
        check("hold_stable", 64'(instr), 64'(expected_instr));
        check("hold_no_read", 64'(bus.avm_read), 64'd0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("update_pc_pulse", 64'(update_pc), 64'd1);
        check("valid_drop", 64'(instr_valid), 64'd0);
        tick();
        check("update_pc_single", 64'(update_pc), 64'd0);
        check("no_read_during_update", 64'(bus.avm_read), 64'd0);
        pc = next_pc;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall_total = 0;
        #1;
        check("rst_read", 64'(bus.avm_read), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_update", 64'(update_pc), 64'd0);
        check("rst_fault", 64'(fetch_fault), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        check("rst_active", 64'(active), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'hBFC0_0000, 32'h2402_0005, 0};
        vecs[1] = '{32'hBFC0_0004, 32'h3C01_1234, 3};
        vecs[2] = '{32'hBFC0_0008, 32'h8C22_0010, 1};
        vecs[3] = '{32'hBFC0_000C, 32'hFFFF_FFFF, 0};
        vecs[4] = '{32'hBFC0_0010, 32'h0000_0000, 2};

        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata = 32'h0;
        pc = 32'hBFC0_0000;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            fetch_one(vecs[i].addr, vecs[i].word, vecs[i].waits);
            retire(vecs[i].word, (i < 4) ? vecs[i+1].addr : 32'hBFC0_0100);
        end

        // Reset asserted mid-read; late readdata must be ignored.
        pc = 32'hBFC0_0100;
        bus.avm_waitrequest = 1'b1;
        tick();
        tick();
        check("wait_before_reset", 64'(bus.avm_read), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_read_drop", 64'(bus.avm_read), 64'd0);
        check("async_valid", 64'(instr_valid), 64'd0);
        check("async_active", 64'(active), 64'd1);
        check("async_stall", 64'(stall_count), 64'd0);
        stall_total = 0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'hDEAD_BEEF;
        tick();
        check("late_data_ignored", 64'(instr), 64'd0);
        reset_n = 1'b1;
        fetch_one(32'hBFC0_0100, 32'h1234_5678, 1);
        retire(32'h1234_5678, 32'h0000_0000);

        // Halt address: no reads ever again, exec_done ignored.
        tick();
        check("halt_active", 64'(active), 64'd0);
        check("halt_fault", 64'(fetch_fault), 64'd0);
        pc = 32'hBFC0_0200;
        for (int k = 0; k < 4; k++) begin
            exec_done = 1'b1;
            tick();
            check("halt_no_read", 64'(bus.avm_read), 64'd0);
            check("halt_no_update", 64'(update_pc), 64'd0);
            check("halt_no_valid", 64'(instr_valid), 64'd0);
        end
        exec_done = 1'b0;

        // Misaligned PC.
        pc = 32'hBFC0_0002;
        do_reset();
        tick();
        check("mis_fault", 64'(fetch_fault), 64'd1);
        check("mis_active", 64'(active), 64'd0);
        check("mis_no_read", 64'(bus.avm_read), 64'd0);
        pc = 32'hBFC0_0000;
        tick();
        tick();
        check("mis_sticky", 64'(fetch_fault), 64'd1);
        check("mis_still_no_read", 64'(bus.avm_read), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
